// File: rtl/game_stream_pkg.sv
// Shared types and constants for the game RAM stream reader.
// Holds the FSM state type and the Avalon bus constants.
package game_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int         AVM_DATA_W = 32;
    localparam logic [3:0] AVM_BE_ALL = 4'b1111;

endpackage

// File: rtl/game_stream_fifo.sv
// Synchronous show-ahead FIFO; head is valid whenever empty is low.
// Ports: clk, reset_n, push/push_data, pop, head, count, full, empty.
module game_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot, so push into a full FIFO is fine then
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/game_ram_stream_reader.sv
// Avalon-MM read master streaming LEN words from BASE onto valid/ready.
// Ports: start/base_addr/length, busy/done, avm_* master, st_* stream.
module game_ram_stream_reader
    import game_stream_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int LEN_W      = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic [3:0]            avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [AVM_DATA_W-1:0] st_data,
    output logic                  st_valid,
    input  logic                  st_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              credit;
    logic              accept;
    logic              resp;
    logic              pop;

    // Reserve a FIFO slot for every outstanding read
    assign credit = ~fifo_full &&
        (32'(inflight) + 32'(fifo_count) < 32'(FIFO_DEPTH));

    // Credit cannot shrink while stalled, so the request stays up
    assign avm_read       = (state == ISSUE) & credit;
    assign avm_address    = addr;
    assign avm_byteenable = AVM_BE_ALL;
    assign accept         = avm_read & ~avm_waitrequest;
    // Beats with nothing outstanding are stale and dropped
    assign resp           = avm_readdatavalid & (inflight != '0);
    assign st_valid       = ~fifo_empty;
    assign pop            = st_valid & st_ready;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (length == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (accept && remaining == LEN_W'(1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && fifo_empty && !resp) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= '0;
        end else begin
            state    <= state_nx;
            inflight <= inflight + CW'(accept) - CW'(resp);
            if (state == IDLE && start) begin
                addr      <= {base_addr[ADDR_W-1:2], 2'b00};
                remaining <= length;
            end else if (accept) begin
                addr      <= addr + ADDR_W'(4);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    game_stream_fifo #(
        .WIDTH(AVM_DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (resp),
        .push_data(avm_readdata),
        .pop      (pop),
        .head     (st_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_game_ram_stream_reader.sv
// Scoreboard bench for game_ram_stream_reader with a 1-cycle slave.
// Expected addresses/words are queued at start and popped on output.
module tb_game_ram_stream_reader;

    localparam int AW = 17;
    localparam int LW = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest = 1'b0;
    logic [31:0]   avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic [31:0]   st_data;
    logic          st_valid;
    logic          st_ready = 1'b0;

    game_ram_stream_reader #(
        .ADDR_W(AW),
        .LEN_W(LW),
        .FIFO_DEPTH(8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_byteenable   (avm_byteenable),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0]   exp_data[$];
    logic [AW-1:0] exp_addr[$];
    int acc_cnt = 0, recv_cnt = 0, rd_cycles = 0, sv_cycles = 0;
    int done_cnt = 0, busy_cycles = 0, inflight_m = 0, max_infl = 0;
    int cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    bit rand_wait = 0, rand_ready = 0, ready_fixed = 0;
    bit stall_prev = 0, hold_prev = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_data = '0;

    // Slave: one-cycle read latency, mem[i] = A5000000 + i
    always @(posedge clk) begin
        avm_readdatavalid <= avm_read & ~avm_waitrequest;
        avm_readdata <= 32'hA500_0000 + 32'(avm_address[AW-1:2]);
    end

    always @(posedge clk) begin
        #1;
        avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        st_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (avm_read) rd_cycles++;
            if (busy) busy_cycles++;
            if (stall_prev) begin
                tests++;
                if (avm_read !== 1'b1 || avm_address !== prev_addr) begin
                    fails++;
                    $display("FAIL hold: read=%b addr=%h want 1/%h",
                             avm_read, avm_address, prev_addr);
                end
            end
            stall_prev = avm_read & avm_waitrequest;
            prev_addr = avm_address;
            if (avm_read && !avm_waitrequest) begin
                acc_cnt++;
                inflight_m++;
                tests++;
                if (exp_addr.size() == 0) begin
                    fails++;
                    $display("FAIL addr_extra: got %h want none",
                             avm_address);
                end else begin
                    logic [AW-1:0] ea;
                    ea = exp_addr.pop_front();
                    if (avm_address !== ea) begin
                        fails++;
                        $display("FAIL addr: got %h want %h",
                                 avm_address, ea);
                    end
                end
            end
            if (avm_readdatavalid && inflight_m > 0) inflight_m--;
            if (inflight_m > max_infl) max_infl = inflight_m;
            if (inflight_m > 8) begin
                tests++;
                fails++;
                $display("FAIL inflight: got %0d want <=8", inflight_m);
            end
            if (hold_prev) begin
                tests++;
                if (st_valid !== 1'b1 || st_data !== prev_data) begin
                    fails++;
                    $display("FAIL st_stable: got %b/%h want 1/%h",
                             st_valid, st_data, prev_data);
                end
            end
            hold_prev = st_valid & ~st_ready;
            prev_data = st_data;
            if (st_valid) sv_cycles++;
            if (st_valid && st_ready) begin
                recv_cnt++;
                last_hs_cyc = cyc;
                tests++;
                if (exp_data.size() == 0) begin
                    fails++;
                    $display("FAIL st_extra: got %h want none", st_data);
                end else begin
                    logic [31:0] ed;
                    ed = exp_data.pop_front();
                    if (st_data !== ed) begin
                        fails++;
                        $display("FAIL st_data: got %h want %h",
                                 st_data, ed);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                tests++;
                if (!busy) begin
                    fails++;
                    $display("FAIL done_busy: busy=%b want 1", busy);
                end
            end
        end
    end

    task automatic push_job(input logic [AW-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = ((int'(b) >> 2) + i) & 'h7FFF;
            exp_addr.push_back(AW'(w << 2));
            exp_data.push_back(32'hA500_0000 + 32'(w));
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n);
        push_job(b, n);
        @(posedge clk);
        #1;
        base_addr = b;
        length = LW'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim, input string nm);
        int n;
        n = 0;
        while (done_cnt == d0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (done_cnt == d0) begin
            fails++;
            $display("FAIL %s_timeout: got no done want done", nm);
        end
        @(posedge clk);
    endtask

    task automatic check_empty(input string nm);
        tests++;
        if (exp_data.size() != 0 || exp_addr.size() != 0) begin
            fails++;
            $display("FAIL %s_left: got %0d/%0d want 0/0", nm,
                     exp_data.size(), exp_addr.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, avm_read, st_valid} !== 4'b0 ||
            avm_address !== '0 || avm_byteenable !== 4'hF) begin
            fails++;
            $display("FAIL reset: got %b%b%b%b a=%h be=%h want 0 be=f",
                     busy, done, avm_read, st_valid, avm_address,
                     avm_byteenable);
        end
        reset_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_basic();
        int d0, r0;
        d0 = done_cnt;
        r0 = recv_cnt;
        ready_fixed = 1;
        do_start(17'h40, 4);
        tests++;
        if (avm_read !== 1'b1 || avm_address !== 17'h40) begin
            fails++;
            $display("FAIL first_read: got %b/%h want 1/00040",
                     avm_read, avm_address);
        end
        wait_done(d0, 50, "basic");
        tests++;
        if (recv_cnt - r0 != 4 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL basic_cnt: got %0d/%0d want 4/1",
                     recv_cnt - r0, done_cnt - d0);
        end
        tests++;
        if (done_cyc - last_hs_cyc != 2) begin
            fails++;
            $display("FAIL done_lat: got %0d want 2",
                     done_cyc - last_hs_cyc);
        end
        check_empty("basic");
    endtask

    task automatic test_zero_len();
        int d0, rd0, sv0, b0;
        d0 = done_cnt;
        rd0 = rd_cycles;
        sv0 = sv_cycles;
        b0 = busy_cycles;
        do_start(17'h80, 0);
        wait_done(d0, 10, "zero");
        tests++;
        if (rd_cycles != rd0 || sv_cycles != sv0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL zero_len: got rd=%0d sv=%0d dn=%0d want 0/0/1",
                     rd_cycles - rd0, sv_cycles - sv0, done_cnt - d0);
        end
        tests++;
        if (busy_cycles - b0 < 1 || busy_cycles - b0 > 2) begin
            fails++;
            $display("FAIL zero_busy: got %0d want 1..2",
                     busy_cycles - b0);
        end
    endtask

    task automatic test_backpressure();
        int d0, r0, a0;
        d0 = done_cnt;
        r0 = recv_cnt;
        a0 = acc_cnt;
        ready_fixed = 0;
        do_start(17'h100, 20);
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (acc_cnt - a0 != 8 || avm_read !== 1'b0) begin
            fails++;
            $display("FAIL credit: got acc=%0d read=%b want 8/0",
                     acc_cnt - a0, avm_read);
        end
        tests++;
        if (st_valid !== 1'b1 || recv_cnt != r0) begin
            fails++;
            $display("FAIL bp_hold: got v=%b rx=%0d want 1/0",
                     st_valid, recv_cnt - r0);
        end
        ready_fixed = 1;
        wait_done(d0, 200, "bp");
        tests++;
        if (recv_cnt - r0 != 20) begin
            fails++;
            $display("FAIL bp_cnt: got %0d want 20", recv_cnt - r0);
        end
        check_empty("bp");
    endtask

    task automatic test_random_stall();
        int d0, r0;
        d0 = done_cnt;
        r0 = recv_cnt;
        max_infl = 0;
        rand_wait = 1;
        rand_ready = 1;
        do_start(17'h400, 100);
        wait_done(d0, 3000, "rand");
        rand_wait = 0;
        rand_ready = 0;
        ready_fixed = 1;
        tests++;
        if (recv_cnt - r0 != 100 || max_infl < 1) begin
            fails++;
            $display("FAIL rand_cnt: got %0d maxinf=%0d want 100 >=1",
                     recv_cnt - r0, max_infl);
        end
        check_empty("rand");
    endtask

    task automatic test_wrap();
        int d0, r0;
        d0 = done_cnt;
        r0 = recv_cnt;
        do_start(17'h1FFF8, 4);
        wait_done(d0, 50, "wrap");
        tests++;
        if (recv_cnt - r0 != 4) begin
            fails++;
            $display("FAIL wrap_cnt: got %0d want 4", recv_cnt - r0);
        end
        check_empty("wrap");
    endtask

    task automatic test_reset_mid();
        int d0, r0, n;
        d0 = done_cnt;
        r0 = recv_cnt;
        ready_fixed = 1;
        do_start(17'h200, 20);
        n = 0;
        while (recv_cnt - r0 < 5 && n < 100) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (recv_cnt - r0 < 5) begin
            fails++;
            $display("FAIL mid_timeout: got %0d want 5", recv_cnt - r0);
        end
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_data.delete();
        exp_addr.delete();
        inflight_m = 0;
        stall_prev = 0;
        hold_prev = 0;
        repeat (2) @(posedge clk);
        tests++;
        if (done_cnt != d0 || st_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_flush: got dn=%0d v=%b want 0/0",
                     done_cnt - d0, st_valid);
        end
        r0 = recv_cnt;
        do_start(17'h0, 2);
        wait_done(d0, 50, "mid");
        tests++;
        if (recv_cnt - r0 != 2 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL mid_cnt: got %0d/%0d want 2/1",
                     recv_cnt - r0, done_cnt - d0);
        end
        check_empty("mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_random_stall();
        test_wrap();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
